// File: rtl/lut_layer_stream.sv
// lut_layer_stream: a streaming layer of LUT neurons.
// Each neuron owns a 2^ADDR_W x OUT_BITS table. An input beat carries one
// table address per neuron. Beats pass through two register stages: S1 holds
// the addresses and S2 holds the looked-up outputs.
// Tables can only be written while the pipeline is empty.
// Optional feature macro: LUT_READBACK_EN adds cfg_re / cfg_rdata so the
// tables can be read back.
//
// Handshake semantics: a beat moves on an interface at a rising edge where
// valid and ready are both high. A producer holds valid and data stable until
// the beat is accepted. The input side drops s_ready while cfg_we is high so
// that a table write wins over a stream beat in the same cycle. The output
// side holds m_data stable while m_valid=1 and m_ready=0.
module lut_layer_stream #(
    parameter int N_NEURONS = 4,
    parameter int FAN_IN    = 4,
    parameter int IN_BITS   = 2,
    parameter int OUT_BITS  = 2,
    localparam int ADDR_W   = FAN_IN * IN_BITS,
    localparam int NEUR_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [N_NEURONS*ADDR_W-1:0]   s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] m_data,
    input  logic                          cfg_we,
    output logic                          cfg_ready,
    input  logic [NEUR_W-1:0]             cfg_neuron,
    input  logic [ADDR_W-1:0]             cfg_addr,
`ifdef LUT_READBACK_EN
    input  logic                          cfg_re,
    output logic [OUT_BITS-1:0]           cfg_rdata,
`endif
    input  logic [OUT_BITS-1:0]           cfg_wdata
);

    localparam int DEPTH = 1 << ADDR_W;
    // One past the last valid neuron index, one bit wider than cfg_neuron
    // so that indices at or above N_NEURONS can be detected.
    localparam logic [NEUR_W:0] N_LIMIT = (NEUR_W + 1)'(N_NEURONS);

    // Neuron tables. These are not reset, so their contents survive rst_n.
    logic [OUT_BITS-1:0] lut_mem [N_NEURONS][DEPTH];

    logic                          s1_valid;
    logic [N_NEURONS*ADDR_W-1:0]   s1_data;
    logic [N_NEURONS*OUT_BITS-1:0] lut_out;
    logic                          advance;
    logic                          s1_load;
    logic                          s_accept;
    logic                          neuron_ok;
    logic                          cfg_wr;

    // S2 may take a new beat when it is empty or its beat leaves this cycle.
    assign advance   = !m_valid | m_ready;
    // S1 may take a new beat when it is empty or its beat moves into S2.
    assign s1_load   = !s1_valid | advance;
    assign s_ready   = s1_load & !cfg_we;
    assign s_accept  = s_valid & s_ready;

    // Writes are accepted only with nothing in flight. This way a beat never
    // sees half-updated tables, and every later beat sees the new value.
    assign cfg_ready = !s1_valid & !m_valid;
    assign neuron_ok = ({1'b0, cfg_neuron} < N_LIMIT);
    assign cfg_wr    = cfg_we & cfg_ready & neuron_ok;

    // Table write port: one entry per accepted write; out-of-range neurons are dropped.
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            lut_mem[cfg_neuron][cfg_addr] <= cfg_wdata;
        end
    end

    // Combinational lookup of every neuron's table using the address fields held in S1.
    always_comb begin
        lut_out = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            lut_out[k*OUT_BITS +: OUT_BITS] = lut_mem[k][s1_data[k*ADDR_W +: ADDR_W]];
        end
    end

    // Stage S1: capture the address beat on accept; empties when its beat moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_load) begin
            s1_valid <= s_accept;
            if (s_accept) begin
                s1_data <= s_data;
            end
        end
    end

    // Stage S2: register the lookup result; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (advance) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_data <= lut_out;
            end
        end
    end

`ifdef LUT_READBACK_EN
    logic cfg_rd;

    // Reads are gated like writes, so a read never competes with live traffic.
    assign cfg_rd = cfg_re & cfg_ready & neuron_ok;

    // Registered readback of the addressed entry; holds its last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rdata <= '0;
        end else if (cfg_rd) begin
            cfg_rdata <= lut_mem[cfg_neuron][cfg_addr];
        end
    end
`endif

endmodule

// File: tb/tb_lut_layer_stream.sv
// Bench for lut_layer_stream with the default configuration (4 neurons,
// 8-bit addresses, 2-bit outputs).
// A table of beat records gives, for each beat, its addresses and hand-computed outputs.
// The tables are loaded from that record table, and expected outputs go
// through a queue that the output monitor pops in order.
module tb_lut_layer_stream;

    localparam int NN = 4;
    localparam int AW = 8;
    localparam int OB = 2;
    localparam int DW = NN * AW;
    localparam int MW = NN * OB;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          s_valid    = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data     = '0;
    logic          m_valid;
    logic          m_ready    = 1'b0;
    logic [MW-1:0] m_data;
    logic          cfg_we     = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_neuron = '0;
    logic [AW-1:0] cfg_addr   = '0;
    logic [OB-1:0] cfg_wdata  = '0;
`ifdef LUT_READBACK_EN
    logic          cfg_re     = 1'b0;
    logic [OB-1:0] cfg_rdata;
`endif

    lut_layer_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
`ifdef LUT_READBACK_EN
        .cfg_re     (cfg_re),
        .cfg_rdata  (cfg_rdata),
`endif
        .cfg_wdata  (cfg_wdata)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [DW-1:0] s_data;
        logic [MW-1:0] exp;
    } vec_t;

    vec_t          vecs [8];
    logic [MW-1:0] exp_q [$];
    int            out_cyc [$];
    int            n_out    = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [MW-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: compare every output handshake against the queue head
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            n_out++;
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h, required no output", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("stream_data", 32'(m_data), 32'(mon_exp));
            end
        end
    end

    // Driver tasks; each starts and ends 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] n, input logic [AW-1:0] a, input logic [OB-1:0] d);
        cfg_we     = 1'b1;
        cfg_neuron = n;
        cfg_addr   = a;
        cfg_wdata  = d;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [MW-1:0] e);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got s_ready=0 for 20 cycles, required accept");
        end
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !m_valid) break;
            tick();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [MW-1:0] held;
    int            k;
    int            base;

    initial begin
        vecs[0] = '{32'h01020304, 8'h1B};
        vecs[1] = '{32'h11121314, 8'hE4};
        vecs[2] = '{32'h21222324, 8'h4E};
        vecs[3] = '{32'h31323334, 8'hB1};
        vecs[4] = '{32'h41424344, 8'h27};
        vecs[5] = '{32'h51525354, 8'hD8};
        vecs[6] = '{32'h61626364, 8'h93};
        vecs[7] = '{32'h71727374, 8'h6C};

        // Reset: low for 3 cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        check("post_rst_m_data", 32'(m_data), 32'd0);
        tick();

        // Load the tables so that each record's addresses yield its outputs
        for (int i = 0; i < 8; i++) begin
            for (int n = 0; n < NN; n++) begin
                cfg_write(2'(n), vecs[i].s_data[n*AW +: AW], vecs[i].exp[n*OB +: OB]);
            end
        end

        // Single lookup and its latency
        cfg_write(2'd0, 8'h40, 2'b01);
        cfg_write(2'd3, 8'hFF, 2'b11);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hFF020340;
        @(negedge clk);
        check("single_accept", 32'(s_ready), 32'd1);
        exp_q.push_back(8'hD9);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1_m_valid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("latency_cycle2_m_valid", 32'(m_valid), 32'd1);
        check("single_n0", 32'(m_data[1:0]), 32'd1);
        check("single_n3", 32'(m_data[7:6]), 32'd3);
        tick();
        drain();

        // 8 back-to-back beats with no backpressure
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            send_beat(vecs[i].s_data, vecs[i].exp);
        end
        drain();
        check("b2b_count", 32'(n_out - base), 32'd8);
        for (int i = 1; i < 8; i++) begin
            check("b2b_consecutive", 32'(out_cyc[base+i] - out_cyc[base+i-1]), 32'd1);
        end

        // Backpressure: m_ready low for 4 cycles with s_valid held high
        m_ready = 1'b0;
        k       = 0;
        held    = '0;
        s_valid = 1'b1;
        s_data  = vecs[0].s_data;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) held = m_data;
            if (c == 3) begin
                check("bp_s_ready", 32'(s_ready), 32'd0);
                check("bp_m_valid", 32'(m_valid), 32'd1);
                check("bp_hold", 32'(m_data), 32'(held));
                check("bp_hold_value", 32'(m_data), 32'(vecs[0].exp));
            end
            if (s_ready) begin
                exp_q.push_back(vecs[k].exp);
                k++;
            end
            tick();
            s_data = vecs[k].s_data;
        end
        check("bp_accepts", 32'(k), 32'd2);
        drain();

        // Write attempted with a beat in flight is ignored
        m_ready = 1'b0;
        send_beat(vecs[1].s_data, vecs[1].exp);
        s_valid = 1'b0;
        tick();
        cfg_we     = 1'b1;
        cfg_neuron = 2'd1;
        cfg_addr   = 8'h03;
        cfg_wdata  = 2'b01;
        @(negedge clk);
        check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        cfg_we = 1'b0;
        drain();
        send_beat(vecs[0].s_data, vecs[0].exp);
        drain();

        // Write and beat together in an empty pipe: the write wins
        cfg_we     = 1'b1;
        cfg_neuron = 2'd1;
        cfg_addr   = 8'h03;
        cfg_wdata  = 2'b01;
        s_valid    = 1'b1;
        s_data     = vecs[0].s_data;
        @(negedge clk);
        check("collide_s_ready", 32'(s_ready), 32'd0);
        check("collide_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_we = 1'b0;
        send_beat(vecs[0].s_data, 8'h17);
        drain();

        // Reset mid-stream discards in-flight beats; tables are retained
        m_ready = 1'b0;
        send_beat(vecs[2].s_data, vecs[2].exp);
        send_beat(vecs[3].s_data, vecs[3].exp);
        s_valid = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data", 32'(m_data), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        send_beat(vecs[3].s_data, vecs[3].exp);
        drain();

`ifdef LUT_READBACK_EN
        // Table readback
        cfg_write(2'd2, 8'h1C, 2'b10);
        cfg_re     = 1'b1;
        cfg_neuron = 2'd2;
        cfg_addr   = 8'h1C;
        tick();
        cfg_re = 1'b0;
        @(negedge clk);
        check("readback", 32'(cfg_rdata), 32'd2);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
